// File: rtl/shared_tick_timer_arbiter.sv
// shared_tick_timer_arbiter: one countdown timer shared by NUM_REQ requesters.
// Each owner loads its delay and counts tickIn pulses. When the count ends, the
// owner gets a one-cycle done pulse.
// Build option: TIMER_ARB_FIXED_PRIORITY_EN selects fixed priority (lowest index
// wins). The default build uses a round-robin arbiter.
module shared_tick_timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tickIn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] delay,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [NUM_REQ-1:0]       done,
  output logic [CNT_W-1:0]         remaining
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t               state, state_nx;
  logic [IDX_W-1:0]     own, own_nx, pick;
  logic                 found;
  logic [CNT_W-1:0]     pick_dly, rem_nx;
  logic [NUM_REQ-1:0]   pick_oh, grant_nx, done_nx;
  logic                 busy_nx;
`ifndef TIMER_ARB_FIXED_PRIORITY_EN
  logic [IDX_W-1:0]     last, last_nx;
`endif

  // Arbiter: choose the winning requester for an IDLE cycle
  always_comb begin
    pick  = '0;
    found = 1'b0;
`ifdef TIMER_ARB_FIXED_PRIORITY_EN
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        pick  = IDX_W'(k);
        found = 1'b1;
      end
    end
`else
    // Search last+1, last+2, ... so the previous owner has the lowest priority
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_REQ]) begin
        pick  = IDX_W'((int'(last) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
`endif
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
    pick_dly      = delay[int'(pick)*CNT_W +: CNT_W];
  end

  // Next-state and next-output logic; every output below is registered
  always_comb begin
    state_nx = state;
    own_nx   = own;
    grant_nx = grant;
    busy_nx  = busy;
    done_nx  = '0;
    rem_nx   = remaining;
`ifndef TIMER_ARB_FIXED_PRIORITY_EN
    last_nx  = last;
`endif
    case (state)
      IDLE: begin
        grant_nx = '0;
        busy_nx  = 1'b0;
        rem_nx   = '0;
        if (found) begin
          grant_nx = pick_oh;
          busy_nx  = 1'b1;
          rem_nx   = pick_dly;
          own_nx   = pick;
`ifndef TIMER_ARB_FIXED_PRIORITY_EN
          last_nx  = pick;
`endif
          // A zero delay finishes immediately: done rises together with grant
          if (pick_dly == '0) begin
            state_nx = DONE;
            done_nx  = pick_oh;
          end else begin
            state_nx = COUNT;
          end
        end
      end
      COUNT: begin
        // Abandon takes precedence over a tick in the same cycle
        if (!req[own]) begin
          state_nx = IDLE;
          grant_nx = '0;
          busy_nx  = 1'b0;
          rem_nx   = '0;
        end else if (tickIn) begin
          if (remaining == CNT_W'(1)) begin
            rem_nx   = '0;
            state_nx = DONE;
            done_nx  = grant;
          end else begin
            rem_nx = remaining - CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        grant_nx = '0;
        busy_nx  = 1'b0;
        rem_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        busy_nx  = 1'b0;
        rem_nx   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      own       <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      done      <= '0;
      remaining <= '0;
`ifndef TIMER_ARB_FIXED_PRIORITY_EN
      last      <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      state     <= state_nx;
      own       <= own_nx;
      grant     <= grant_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      remaining <= rem_nx;
`ifndef TIMER_ARB_FIXED_PRIORITY_EN
      last      <= last_nx;
`endif
    end
  end

endmodule

// File: doc/shared_tick_timer_arbiter.md
Name: shared_tick_timer_arbiter

Overview:
- Shares one countdown timer between NUM_REQ requesters. The timer is clocked by the 100 ms tick pulse from the timer chain.
- Each requester asks for a delay of N ticks. The block arbitrates, loads the shared counter, counts tickIn pulses, and returns a one-cycle done to the owner.
- Sits between the hundred-millisecond tick source and the LED matrix sequencing logic (animation step, scroll, blink requesters).

Parameters:
- NUM_REQ, 4, number of requester channels (2..8)
- CNT_W, 8, width of each delay field and of the shared counter

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- tickIn  input  1  one-cycle tick pulse (100 ms period)
- req  input  NUM_REQ  per-channel request; held high until done or abandoned
- delay  input  NUM_REQ*CNT_W  packed delays; channel i at bits [i*CNT_W +: CNT_W]
- grant  output  NUM_REQ  one-hot owner of the timer, registered
- busy  output  1  high while the timer is owned, registered
- done  output  NUM_REQ  one-cycle completion pulse to the owner, registered
- remaining  output  CNT_W  current counter value, registered

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; grant=0, busy=0, done=0, remaining=0.
  - Round-robin pointer last=NUM_REQ-1, so channel 0 has highest priority first.
  - Reset overrides everything mid-count; no done is issued for an aborted count.
- States: IDLE, COUNT, DONE.
- IDLE:
  - If req==0, stay in IDLE with outputs 0.
  - Otherwise pick the first requesting channel searching last+1, last+2, … modulo NUM_REQ.
  - Next cycle: grant[g]=1, busy=1, remaining=delay[g] (sampled in the IDLE cycle), last=g.
  - Next state is COUNT if delay[g]!=0, else DONE.
- Latency: req seen high in cycle t gives grant at t+1.
- COUNT:
  - A tickIn in the grant-capture cycle is not counted. Counting starts the cycle after grant rises.
  - On each tickIn with remaining>1: remaining-=1.
  - On tickIn with remaining==1: remaining=0, next state DONE.
  - No tickIn: hold.
- Abandon: if req[g] goes low in COUNT, next cycle is IDLE with grant=0, busy=0, remaining=0 and no done. Other channels' req changes are ignored during COUNT.
- DONE:
  - done[g]=1 for exactly one cycle; grant[g] and busy stay 1 in that cycle; remaining=0.
  - Next cycle: IDLE, grant=0, busy=0, done=0.
  - done is issued even if req[g] fell in the DONE cycle.
- Back-to-back: a new grant appears at the earliest 2 cycles after done. If the finished channel keeps req high, it is re-granted only if no other channel is requesting.
- Invariants:
  - grant is zero or one-hot.
  - done is a subset of grant.
  - busy == |grant.
- delay is sampled only at grant. Later changes are ignored until the next grant.
- Arithmetic is unsigned CNT_W. Maximum delay is 2^CNT_W-1 ticks; there is no wrap.

Optional Feature:
- Macro: TIMER_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest index wins. The pointer `last` is removed and a continuously requesting channel 0 can starve the others.
- Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then req=4'b0010 with delay[1]=3 and a tickIn every 10 cycles:
  - grant=4'b0010 one cycle after req.
  - remaining steps 3→2→1→0.
  - done[1] pulses one cycle after the 3rd counted tick, then grant=0.
- req[2]=1 with delay[2]=0: grant=4'b0100 at t+1 with done[2]=1 in that same cycle, then IDLE at t+2; no tickIn needed.
- req=4'b1111 held, all delays=1: grants rotate 0,1,2,3,0 with one done per grant. With TIMER_ARB_FIXED_PRIORITY_EN defined, channel 0 is granted every time.
- Grant channel 3 with delay=5, drop req[3] after 2 ticks: next cycle grant=0, busy=0, remaining=0, no done; a pending req[0] is granted the cycle after.
- Assert rst while in COUNT with remaining=4: the next cycle shows all outputs 0 and no done. A tickIn coincident with the grant-capture cycle leaves remaining unchanged.
